// File: rtl/conv_seq_ctrl_if.sv
// Control/status bundle between the layer sequencer and its requester.
// The master side issues start/abort/grant; the slave side is the sequencer.
interface conv_seq_ctrl_if #(
  parameter int IMG_H  = 64,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(NUM_CH + 1);

  logic             ready;
  logic [1:0]       mode;
  logic             abort;
  logic             mem_grant;
  logic             busy;
  logic             done;
  logic [5:0]       flags;
  logic [CNT_W-1:0] cnt;
  logic [RW-1:0]    row_idx;
  logic [CW-1:0]    ch_idx;

  modport master (
    output ready, mode, abort, mem_grant,
    input  busy, done, flags, cnt, row_idx, ch_idx
  );

  modport slave (
    input  ready, mode, abort, mem_grant,
    output busy, done, flags, cnt, row_idx, ch_idx
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Layer sequencer for the conv/ReLU/pool/flatten engine: walks rows and
// channels, drives one-hot phase enables, no datapath.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for ready; mode captured on start
// S_LOAD    | fetch KSIZE padded rows into the line buffer (grant-gated)
// S_CONV    | compute one output row, one pixel per cycle
// S_WR_CONV | write the conv row back (grant-gated)
// S_POOL    | 2x2 max-pool over the channel's full map (grant-gated)
// S_FLAT    | stream all channel maps out flattened (grant-gated)
// S_FINISH  | one-cycle done pulse, then back to idle
module conv_seq_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int KSIZE  = 3,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            reset,
  conv_seq_ctrl_if.slave bus
);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(NUM_CH + 1);

  // Last beat index of each phase (phase length minus one).
  localparam logic [CNT_W-1:0] LAST_LD     = CNT_W'(KSIZE * (IMG_W + KSIZE - 1) - 1);
  localparam logic [CNT_W-1:0] LAST_LINE   = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_POOL   = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0] LAST_FLAT_P = CNT_W'(NUM_CH * IMG_W * IMG_H / 4 - 1);
  localparam logic [CNT_W-1:0] LAST_FLAT_F = CNT_W'(NUM_CH * IMG_W * IMG_H - 1);
  localparam logic [RW-1:0]    LAST_ROW    = RW'(IMG_H - 1);
  localparam logic [CW-1:0]    LAST_CH     = CW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CONV, S_WR_CONV, S_POOL, S_FLAT, S_FINISH
  } state_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt_q, nxt_cnt;
  logic [RW-1:0]    row_q, nxt_row;
  logic [CW-1:0]    ch_q, nxt_ch;
  logic [1:0]       mode_q, nxt_mode;
  logic             busy_q, done_q;
  // Phase enables in order: flat, pool, wr_conv, conv, load.
  logic [4:0]       en_q;

  logic             advance;
  logic [CNT_W-1:0] last_idx;
  logic             phase_end;
  state_t           after_ch;

  // Next-state, counter and loop-index computation.
  always_comb begin
    advance   = 1'b0;
    last_idx  = '0;
    unique case (state)
      S_LOAD:    begin advance = bus.mem_grant; last_idx = LAST_LD;   end
      S_CONV:    begin advance = 1'b1;          last_idx = LAST_LINE; end
      S_WR_CONV: begin advance = bus.mem_grant; last_idx = LAST_LINE; end
      S_POOL:    begin advance = bus.mem_grant; last_idx = LAST_POOL; end
      S_FLAT:    begin
        advance  = bus.mem_grant;
        last_idx = mode_q[0] ? LAST_FLAT_P : LAST_FLAT_F;
      end
      default:   begin advance = 1'b0;          last_idx = '0;        end
    endcase
    phase_end = advance && (cnt_q == last_idx);

    // Where a finished channel goes: next channel, flatten, or done.
    if (ch_q == LAST_CH) after_ch = mode_q[1] ? S_FLAT : S_FINISH;
    else                 after_ch = S_LOAD;

    nxt_state = state;
    nxt_cnt   = cnt_q;
    nxt_row   = row_q;
    nxt_ch    = ch_q;
    nxt_mode  = mode_q;

    if (state == S_IDLE) begin
      if (bus.ready) begin
        nxt_state = S_LOAD;
        nxt_cnt   = '0;
        nxt_row   = '0;
        nxt_ch    = '0;
        nxt_mode  = bus.mode;
      end
    end else if (bus.abort || state == S_FINISH) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
      nxt_row   = '0;
      nxt_ch    = '0;
    end else if (phase_end) begin
      nxt_cnt = '0;
      unique case (state)
        S_LOAD: nxt_state = S_CONV;
        S_CONV: nxt_state = S_WR_CONV;
        S_WR_CONV: begin
          if (row_q == LAST_ROW) begin
            nxt_row = '0;
            if (mode_q[0]) begin
              nxt_state = S_POOL;
            end else begin
              nxt_ch    = ch_q + CW'(1);
              nxt_state = after_ch;
            end
          end else begin
            nxt_row   = row_q + RW'(1);
            nxt_state = S_LOAD;
          end
        end
        S_POOL: begin
          nxt_ch    = ch_q + CW'(1);
          nxt_state = after_ch;
        end
        S_FLAT:  nxt_state = S_FINISH;
        default: nxt_state = S_IDLE;
      endcase
    end else if (advance) begin
      nxt_cnt = cnt_q + CNT_W'(1);
    end
  end

  // State and index registers; outputs registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt_q  <= '0;
      row_q  <= '0;
      ch_q   <= '0;
      mode_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      en_q   <= '0;
    end else begin
      state  <= nxt_state;
      cnt_q  <= nxt_cnt;
      row_q  <= nxt_row;
      ch_q   <= nxt_ch;
      mode_q <= nxt_mode;
      busy_q <= (nxt_state != S_IDLE) && (nxt_state != S_FINISH);
      done_q <= (nxt_state == S_FINISH);
      en_q   <= {nxt_state == S_FLAT, nxt_state == S_POOL, nxt_state == S_WR_CONV,
                 nxt_state == S_CONV, nxt_state == S_LOAD};
    end
  end

  // pool_wr depends on this cycle's grant, so it is decoded from the
  // registered pool enable rather than registered itself.
  always_comb begin
    bus.flags = {en_q[4], en_q[3] & bus.mem_grant & (cnt_q[1:0] == 2'b11),
                 en_q[3], en_q[2], en_q[1], en_q[0]};
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cnt     = cnt_q;
  assign bus.row_idx = row_q;
  assign bus.ch_idx  = ch_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: phase-schedule reference model, table of
// whole-run statistics, hand-written reset/abort sequences, random runs.
module tb_conv_seq_ctrl;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int KSIZE  = 3;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int L_LD   = KSIZE * (IMG_W + KSIZE - 1);

  localparam int PH_LOAD = 0, PH_CONV = 1, PH_WR = 2, PH_POOL = 3, PH_FLAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_seq_ctrl_if #(.IMG_H(IMG_H), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) ifc();

  conv_seq_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(KSIZE), .NUM_CH(NUM_CH),
                  .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct {int ph; int len; int row; int ch;} item_t;
  typedef struct {
    logic [1:0] mode; int policy;
    int busy; int ld; int conv; int pool; int pwr; int flat; int ld_first;
  } vec_t;

  item_t sched[$];
  int    beat;
  bit    m_idle, m_fin;
  int    n_vec, n_bad;
  int    st_busy, st_ld, st_conv, st_pool, st_pwr, st_flat, st_done, st_ldf;
  bit    seen_conv;
  vec_t  vec[6];

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Ordered list of phases a run must go through for the captured mode.
  function automatic void build(logic [1:0] md);
    item_t it;
    sched.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < IMG_H; r++) begin
        it = '{PH_LOAD, L_LD,  r, c}; sched.push_back(it);
        it = '{PH_CONV, IMG_W, r, c}; sched.push_back(it);
        it = '{PH_WR,   IMG_W, r, c}; sched.push_back(it);
      end
      if (md[0]) begin
        it = '{PH_POOL, IMG_W * IMG_H, 0, c}; sched.push_back(it);
      end
    end
    if (md[1]) begin
      it = '{PH_FLAT, md[0] ? NUM_CH * IMG_W * IMG_H / 4 : NUM_CH * IMG_W * IMG_H, 0, NUM_CH};
      sched.push_back(it);
    end
  endfunction

  function automatic void model_reset();
    sched.delete();
    beat   = 0;
    m_idle = 1'b1;
    m_fin  = 1'b0;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit rdy, input logic [1:0] md, input bit ab, input bit gr);
    logic [5:0] ef;
    int  eb, ed, ec;
    bit  active;
    item_t it;
    @(negedge clk);
    ifc.ready = rdy; ifc.mode = md; ifc.abort = ab; ifc.mem_grant = gr;
    #1;
    ef = '0; eb = 0; ed = 0; ec = 0; active = 1'b0;
    if (!m_idle && m_fin) begin
      ed = 1;
    end else if (!m_idle) begin
      it = sched[0];
      active = 1'b1;
      eb = 1;
      ec = beat;
      case (it.ph)
        PH_LOAD: ef[0] = 1'b1;
        PH_CONV: ef[1] = 1'b1;
        PH_WR:   ef[2] = 1'b1;
        PH_POOL: begin ef[3] = 1'b1; ef[4] = gr && (beat % 4 == 3); end
        default: ef[5] = 1'b1;
      endcase
    end
    chk("busy",  int'(ifc.busy),  eb);
    chk("done",  int'(ifc.done),  ed);
    chk("flags", int'(ifc.flags), int'(ef));
    chk("cnt",   int'(ifc.cnt),   ec);
    if (active) begin
      chk("row_idx", int'(ifc.row_idx), it.row);
      chk("ch_idx",  int'(ifc.ch_idx),  it.ch);
    end
    if (ifc.busy) st_busy++;
    if (ifc.flags[0]) st_ld++;
    if (ifc.flags[1]) begin st_conv++; seen_conv = 1'b1; end
    if (ifc.flags[0] && !seen_conv) st_ldf++;
    if (ifc.flags[3]) st_pool++;
    if (ifc.flags[4]) st_pwr++;
    if (ifc.flags[5]) st_flat++;
    if (ifc.done) st_done++;
    @(posedge clk);
    if (m_idle) begin
      if (rdy) begin build(md); beat = 0; m_idle = 1'b0; end
    end else if (ab) begin
      model_reset();
    end else if (m_fin) begin
      m_fin = 1'b0; m_idle = 1'b1;
    end else if (sched[0].ph == PH_CONV || gr) begin
      beat++;
      if (beat == sched[0].len) begin
        void'(sched.pop_front());
        beat = 0;
        if (sched.size() == 0) m_fin = 1'b1;
      end
    end
  endtask

  // policy 0: grant always 1; 1: grant toggles 0/1 inside LOAD only;
  // 2: random grant, stray ready/mode, rare abort.
  task automatic run(input logic [1:0] md, input int policy, input int ab_ch,
                     input int ab_beat, input bit start_ab, input int budget);
    int cyc;
    bit tog, gr, ab, rdy;
    logic [1:0] m2;
    st_busy = 0; st_ld = 0; st_conv = 0; st_pool = 0; st_pwr = 0;
    st_flat = 0; st_done = 0; st_ldf = 0; seen_conv = 1'b0;
    tog = 1'b0; cyc = 0;
    step(1'b1, md, start_ab, 1'b1);
    while (!m_idle && cyc < budget) begin
      gr = 1'b1; ab = 1'b0; rdy = 1'b0; m2 = md;
      if (policy == 1) begin
        if (!m_fin && sched[0].ph == PH_LOAD) begin gr = tog; tog = ~tog; end
        else tog = 1'b0;
      end else if (policy == 2) begin
        gr  = ($urandom_range(0, 3) != 0);
        rdy = $urandom_range(0, 1) == 1;
        m2  = 2'($urandom_range(0, 3));
        ab  = ($urandom_range(0, 599) == 0);
      end
      if (ab_ch >= 0 && !m_fin && sched[0].ph == PH_POOL &&
          sched[0].ch == ab_ch && beat == ab_beat) ab = 1'b1;
      step(rdy, m2, ab, gr);
      cyc++;
    end
    chk("run_timeout", int'(m_idle), 1);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    ifc.ready = 1'b0; ifc.mode = 2'b00; ifc.abort = 1'b0; ifc.mem_grant = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  int'(ifc.busy),  0);
    chk("rst_done",  int'(ifc.done),  0);
    chk("rst_flags", int'(ifc.flags), 0);
    chk("rst_cnt",   int'(ifc.cnt),   0);
    reset = 1'b1;

    vec[0] = '{2'd0, 0, 208, 144, 32,  0, 0,  0, 18};
    vec[1] = '{2'd3, 0, 248, 144, 32, 32, 8,  8, 18};
    vec[2] = '{2'd2, 0, 240, 144, 32,  0, 0, 32, 18};
    vec[3] = '{2'd1, 0, 240, 144, 32, 32, 8,  0, 18};
    vec[4] = '{2'd0, 1, 352, 288, 32,  0, 0,  0, 36};
    vec[5] = '{2'd3, 1, 392, 288, 32, 32, 8,  8, 36};
    for (int i = 0; i < 6; i++) begin
      run(vec[i].mode, vec[i].policy, -1, 0, 1'b0, 2000);
      chk("tbl_busy",     st_busy, vec[i].busy);
      chk("tbl_ld",       st_ld,   vec[i].ld);
      chk("tbl_conv",     st_conv, vec[i].conv);
      chk("tbl_pool",     st_pool, vec[i].pool);
      chk("tbl_pool_wr",  st_pwr,  vec[i].pwr);
      chk("tbl_flat",     st_flat, vec[i].flat);
      chk("tbl_ld_first", st_ldf,  vec[i].ld_first);
      chk("tbl_done",     st_done, 1);
      step(1'b0, 2'b00, 1'b0, 1'b1);
    end

    // Abort at beat 5 of channel 1 pooling, then restart from channel 0.
    run(2'd1, 0, 1, 5, 1'b0, 2000);
    chk("abort_no_done", st_done, 0);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("abort_row", int'(ifc.row_idx), 0);
    chk("abort_ch",  int'(ifc.ch_idx),  0);
    run(2'd0, 0, -1, 0, 1'b1, 2000);
    chk("restart_busy", st_busy, 208);
    chk("restart_done", st_done, 1);

    // Asynchronous reset in the middle of a WR_CONV phase.
    step(1'b1, 2'd3, 1'b0, 1'b1);
    for (int k = 0; k < 500; k++) begin
      if (!m_idle && !m_fin && sched[0].ph == PH_WR && sched[0].row == 2 && beat == 2) break;
      step(1'b0, 2'd3, 1'b0, 1'b1);
    end
    chk("pre_rst_row", int'(ifc.row_idx), 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy",  int'(ifc.busy),    0);
    chk("arst_done",  int'(ifc.done),    0);
    chk("arst_flags", int'(ifc.flags),   0);
    chk("arst_cnt",   int'(ifc.cnt),     0);
    chk("arst_row",   int'(ifc.row_idx), 0);
    chk("arst_ch",    int'(ifc.ch_idx),  0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 2'b00, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      run(2'($urandom_range(0, 3)), 2, -1, 0, 1'($urandom_range(0, 1)), 3000);
      step(1'b0, 2'b00, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
